// File: rtl/pkt_phv_merger_pkg.sv
// Shared definitions for the packet/PHV merger: beat tag encodings, PHV metadata layout,
// FIFO entry format and merge FSM states.
package pkt_phv_merger_pkg;

   localparam int HEAD_WIDTH   = 1024;
   localparam int DATA_W       = 128;
   localparam int BEAT_W       = 134;
   localparam int ENTRY_W      = BEAT_W + 1;
   localparam int PHV_DROP_BIT = 16;
   localparam int PORT_LSB     = 0;
   localparam int PORT_W       = 8;

   typedef enum logic [1:0] {
      TAG_HEAD = 2'b01,
      TAG_TAIL = 2'b10,
      TAG_BODY = 2'b11
   } tag_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MERGE,
      ST_DROP
   } state_e;

   // Stand-in for an admission-dropped packet; keeps its PHV paired with a FIFO entry.
   localparam logic [ENTRY_W-1:0] DROP_MARKER = {1'b1, TAG_TAIL, {(BEAT_W-2){1'b0}}};

   function automatic logic is_tag(input logic [BEAT_W-1:0] beat, input tag_e tag);
      return beat[BEAT_W-1 -: 2] == tag;
   endfunction

endpackage

// File: rtl/pkt_phv_merger_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags and a free-entry count.
// A push and a pop in the same cycle are both honoured, even when full.
module pkt_phv_merger_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      free
);

   localparam int          DEPTH_I = 1 << AW;
   localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];

   logic [WIDTH-1:0] mem [DEPTH_I];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH);
   assign free    = DEPTH - count;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array has no reset; pointers and count define validity, so stale words are never read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/pkt_phv_merger.sv
// Packet/PHV merger: buffers packet beats until their processed PHV returns, writes the
// PHV words over the packet head and emits the packet downstream with valid/ready.
module pkt_phv_merger
   import pkt_phv_merger_pkg::*;
#(
   parameter int PHV_WIDTH     = HEAD_WIDTH,
   parameter int PKT_NUM       = PHV_WIDTH / DATA_W - 1,
   parameter int PKT_FIFO_AW   = 8,
   parameter int PHV_FIFO_AW   = 3,
   parameter int MAX_PKT_BEATS = 128
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pkt_valid,
   input  logic [BEAT_W-1:0]    i_pkt,
   input  logic                 i_phv_valid,
   input  logic [PHV_WIDTH-1:0] i_phv,
   output logic                 o_pkt_valid,
   output logic [BEAT_W-1:0]    o_pkt,
   input  logic                 i_pkt_ready,
   output logic [PORT_W-1:0]    o_outport,
   output logic [15:0]          o_drop_cnt,
   output logic                 o_err
);

   localparam int                   IDX_W      = (PKT_NUM > 0) ? $clog2(PKT_NUM + 1) : 1;
   localparam int                   CNT_W      = $clog2(MAX_PKT_BEATS + 1);
   localparam int                   ADMIT_I    = MAX_PKT_BEATS + 1;
   localparam logic [PKT_FIFO_AW:0] ADMIT_FREE = ADMIT_I[PKT_FIFO_AW:0];
   localparam logic [CNT_W-1:0]     MAX_BEATS  = MAX_PKT_BEATS[CNT_W-1:0];

   logic                 pf_push, pf_pop, pf_full, pf_empty;
   logic [ENTRY_W-1:0]   pf_din, pf_dout;
   logic [PKT_FIFO_AW:0] pf_free;
   logic                 hf_push, hf_pop, hf_full, hf_empty;
   logic [PHV_WIDTH-1:0] hf_dout;
   logic [PHV_FIFO_AW:0] hf_free;

   logic                 is_head;
   logic                 in_active, in_drop, in_err;
   logic [CNT_W-1:0]     in_cnt;

   state_e               state_q, state_d;
   logic                 load_phv, out_load, drop_inc, out_free;
   logic [PHV_WIDTH-1:0] phv_q;
   logic [IDX_W-1:0]     beat_idx;
   logic [BEAT_W-1:0]    merged;
   logic                 unused_ok;

   assign unused_ok = ^{pf_full, hf_free};
   assign is_head   = is_tag(i_pkt, TAG_HEAD);
   assign hf_push   = i_phv_valid && !hf_full;
   assign out_free  = !o_pkt_valid || i_pkt_ready;

   pkt_phv_merger_fifo #(.WIDTH(ENTRY_W), .AW(PKT_FIFO_AW)) u_pkt_fifo (
      .clk(i_clk), .rst(i_rst), .push(pf_push), .din(pf_din), .pop(pf_pop),
      .dout(pf_dout), .full(pf_full), .empty(pf_empty), .free(pf_free)
   );

   pkt_phv_merger_fifo #(.WIDTH(PHV_WIDTH), .AW(PHV_FIFO_AW)) u_phv_fifo (
      .clk(i_clk), .rst(i_rst), .push(hf_push), .din(i_phv), .pop(hf_pop),
      .dout(hf_dout), .full(hf_full), .empty(hf_empty), .free(hf_free)
   );

   // Admission is decided once per packet on its head; the reserved entry always fits a drop marker.
   // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      pf_push = 1'b0;
      pf_din  = {1'b0, i_pkt};
      in_err  = 1'b0;
      if (i_pkt_valid) begin
         if (is_head) begin
            pf_push = 1'b1;
            if (pf_free < ADMIT_FREE) pf_din = DROP_MARKER;
         end else if (!in_active || in_cnt >= MAX_BEATS) begin
            in_err = 1'b1;
         end else begin
            pf_push = !in_drop;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         in_active <= 1'b0;
         in_drop   <= 1'b0;
         in_cnt    <= '0;
      end else if (i_pkt_valid) begin
         if (is_head) begin
            in_active <= 1'b1;
            in_drop   <= (pf_free < ADMIT_FREE);
            in_cnt    <= CNT_W'(1);
         end else if (in_active) begin
            if (is_tag(i_pkt, TAG_TAIL)) in_active <= 1'b0;
            if (in_cnt < MAX_BEATS) in_cnt <= in_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      hf_pop   = 1'b0;
      pf_pop   = 1'b0;
      load_phv = 1'b0;
      out_load = 1'b0;
      drop_inc = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!pf_empty && !hf_empty) begin
               hf_pop   = 1'b1;
               load_phv = 1'b1;
               if (pf_dout[ENTRY_W-1]) begin
                  pf_pop   = 1'b1;
                  drop_inc = 1'b1;
               end else if (hf_dout[PHV_DROP_BIT]) begin
                  state_d = ST_DROP;
               end else begin
                  state_d = ST_MERGE;
               end
            end
         end
         ST_MERGE: begin
            // A beat leaves the FIFO when it moves into the output register.
            if (!pf_empty && out_free) begin
               pf_pop   = 1'b1;
               out_load = 1'b1;
               if (is_tag(pf_dout[BEAT_W-1:0], TAG_TAIL)) state_d = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (!pf_empty) begin
               pf_pop = 1'b1;
               if (is_tag(pf_dout[BEAT_W-1:0], TAG_TAIL)) begin
                  drop_inc = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      merged = pf_dout[BEAT_W-1:0];
      if (int'(beat_idx) < PKT_NUM)
         merged[DATA_W-1:0] = phv_q[PHV_WIDTH-1-DATA_W*int'(beat_idx) -: DATA_W];
   end

   // o_outport changes only together with a head beat, so it is stable head through tail.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         phv_q       <= '0;
         beat_idx    <= '0;
         o_pkt_valid <= 1'b0;
         o_pkt       <= '0;
         o_outport   <= '0;
      end else begin
         if (load_phv) begin
            phv_q    <= hf_dout;
            beat_idx <= '0;
         end else if (out_load && int'(beat_idx) < PKT_NUM) begin
            beat_idx <= beat_idx + 1'b1;
         end
         if (out_load) begin
            o_pkt_valid <= 1'b1;
            o_pkt       <= merged;
            if (beat_idx == '0) o_outport <= phv_q[PORT_LSB +: PORT_W];
         end else if (i_pkt_ready) begin
            o_pkt_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_drop_cnt <= '0;
         o_err      <= 1'b0;
      end else begin
         if (drop_inc && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
         if (in_err || (i_phv_valid && hf_full)) o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pkt_phv_merger.sv
// Self-checking bench for pkt_phv_merger: random packets and PHVs, expected beats queued from
// a packet-level reference model and compared by a monitor on every output handshake.
module tb_pkt_phv_merger;

   localparam int         PHV_W      = 1024;
   localparam int         NWORDS     = 8;
   localparam int         FIFO_DEPTH = 256;
   localparam int         MAX_BEATS  = 128;
   localparam logic [1:0] T_HEAD     = 2'b01;
   localparam logic [1:0] T_BODY     = 2'b11;
   localparam logic [1:0] T_TAIL     = 2'b10;

   logic             i_clk, i_rst;
   logic             i_pkt_valid, i_phv_valid, i_pkt_ready;
   logic [133:0]     i_pkt;
   logic [PHV_W-1:0] i_phv;
   logic             o_pkt_valid, o_err;
   logic [133:0]     o_pkt;
   logic [7:0]       o_outport;
   logic [15:0]      o_drop_cnt;

   pkt_phv_merger dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_pkt_valid(i_pkt_valid), .i_pkt(i_pkt),
      .i_phv_valid(i_phv_valid), .i_phv(i_phv),
      .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt), .i_pkt_ready(i_pkt_ready),
      .o_outport(o_outport), .o_drop_cnt(o_drop_cnt), .o_err(o_err)
   );

   typedef struct packed {
      logic [133:0] beat;
      logic [7:0]   port;
   } exp_t;

   exp_t         exp_q[$];
   logic [133:0] pend_beats[$];
   int           pend_len[$];
   bit           pend_adm[$];
   int           occ, exp_drop, checks, errors, hs_cnt;
   bit           rand_ready;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Packet model: admission from modelled occupancy, beats parked until their PHV is issued.
   task automatic send_packet(input int len, input int max_gap);
      bit           adm;
      logic [1:0]   tag;
      logic [133:0] b;
      adm = (FIFO_DEPTH - occ) >= MAX_BEATS + 1;
      occ += adm ? len : 1;
      pend_len.push_back(len);
      pend_adm.push_back(adm);
      for (int i = 0; i < len; i++) begin
         tag = (i == 0) ? T_HEAD : (i == len - 1) ? T_TAIL : T_BODY;
         b   = {tag, 4'($urandom), rand128()};
         pend_beats.push_back(b);
         i_pkt       = b;
         i_pkt_valid = 1'b1;
         tick();
         i_pkt_valid = 1'b0;
         repeat ($urandom_range(0, max_gap)) tick();
      end
   endtask

   task automatic send_phv(input bit drop, input logic [7:0] port);
      logic [127:0]     w [NWORDS];
      logic [PHV_W-1:0] phv;
      logic [133:0]     b;
      int               len;
      bit               adm;
      for (int i = 0; i < NWORDS; i++) w[i] = rand128();
      w[NWORDS-1][16]  = drop;
      w[NWORDS-1][7:0] = port;
      phv = '0;
      for (int i = 0; i < NWORDS; i++) phv = {phv[PHV_W-129:0], w[i]};
      len = pend_len.pop_front();
      adm = pend_adm.pop_front();
      if (!adm || drop) exp_drop++;
      for (int i = 0; i < len; i++) begin
         b = pend_beats.pop_front();
         if (adm && !drop) begin
            if (i < NWORDS - 1) b[127:0] = w[i];
            exp_q.push_back('{beat: b, port: port});
         end
      end
      i_phv       = phv;
      i_phv_valid = 1'b1;
      tick();
      i_phv_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      check("drain_left", 134'(exp_q.size()), 134'(0));
      repeat (140) tick();
      occ = 0;
      check("drop_cnt", 134'(o_drop_cnt), 134'(exp_drop));
   endtask

   task automatic do_reset(input string name);
      i_rst       = 1'b1;
      i_pkt_valid = 1'b0;
      i_phv_valid = 1'b0;
      exp_q.delete();
      pend_beats.delete();
      pend_len.delete();
      pend_adm.delete();
      occ      = 0;
      exp_drop = 0;
      #1;
      check({name, "_valid_async"}, 134'(o_pkt_valid), 134'(0));
      tick();
      check({name, "_valid_edge"}, 134'(o_pkt_valid), 134'(0));
      tick();
      i_rst = 1'b0;
      tick();
   endtask

   initial begin : ready_drv
      i_pkt_ready = 1'b1;
      forever begin
         tick();
         i_pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      bit           prev_stall;
      logic [133:0] prev_pkt;
      exp_t         e;
      prev_stall = 1'b0;
      prev_pkt   = '0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", 134'(o_pkt_valid), 134'(1));
               check("hold_data", o_pkt, prev_pkt);
            end
            if (o_pkt_valid && i_pkt_ready) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected no beat", o_pkt);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", o_pkt, e.beat);
                  check("outport", 134'(o_outport), 134'(e.port));
               end
            end
            prev_stall = o_pkt_valid && !i_pkt_ready;
            prev_pkt   = o_pkt;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin : main
      int n;
      i_rst       = 1'b1;
      i_pkt_valid = 1'b0;
      i_pkt       = '0;
      i_phv_valid = 1'b0;
      i_phv       = '0;
      rand_ready  = 1'b0;
      occ         = 0;
      exp_drop    = 0;
      checks      = 0;
      errors      = 0;
      hs_cnt      = 0;
      tick();
      tick();
      check("rst_valid", 134'(o_pkt_valid), 134'(0));
      check("rst_pkt", o_pkt, 134'(0));
      check("rst_outport", 134'(o_outport), 134'(0));
      check("rst_drop_cnt", 134'(o_drop_cnt), 134'(0));
      check("rst_err", 134'(o_err), 134'(0));
      i_rst = 1'b0;
      tick();

      // 1: single 10-beat packet, PHV long after the tail
      send_packet(10, 0);
      repeat (20) tick();
      send_phv(1'b0, 8'h5A);
      drain();

      // 2: middle packet of three dropped by its PHV
      send_packet(4, 0);
      send_packet(5, 1);
      send_packet(3, 0);
      send_phv(1'b0, 8'h11);
      send_phv(1'b1, 8'h22);
      send_phv(1'b0, 8'h33);
      drain();

      // 3: 128 free entries left, so the next head is admission-dropped
      send_packet(MAX_BEATS, 0);
      send_packet(4, 0);
      send_phv(1'b0, 8'hA1);
      send_phv(1'b0, 8'hA2);
      drain();
      send_packet(5, 0);
      send_phv(1'b0, 8'hA3);
      drain();

      // 4: random backpressure on short packets
      rand_ready = 1'b1;
      send_packet(6, 0);
      send_phv(1'b0, 8'h66);
      send_packet(6, 0);
      send_phv(1'b0, 8'h67);
      drain();

      // Random mix of lengths, gaps, drops and ports under backpressure
      for (int k = 0; k < 6; k++) begin
         send_packet($urandom_range(2, 12), 1);
         repeat ($urandom_range(0, 5)) tick();
         send_phv($urandom_range(0, 3) == 0, 8'($urandom));
      end
      drain();
      rand_ready = 1'b0;
      repeat (2) tick();

      // 6: reset in the middle of a merge
      hs_cnt = 0;
      send_packet(10, 0);
      send_phv(1'b0, 8'h77);
      n = 0;
      while (hs_cnt < 3 && n < 200) begin
         tick();
         n++;
      end
      check("mid_reset_reached", 134'(hs_cnt >= 3), 134'(1));
      do_reset("mid_reset");
      check("post_reset_drop_cnt", 134'(o_drop_cnt), 134'(0));
      send_packet(4, 0);
      send_phv(1'b0, 8'h3C);
      drain();
      check("post_reset_err", 134'(o_err), 134'(0));

      // 5: nine PHVs with nothing to pop them
      i_phv       = '0;
      i_phv_valid = 1'b1;
      repeat (8) tick();
      check("err_after_8_phv", 134'(o_err), 134'(0));
      tick();
      i_phv_valid = 1'b0;
      check("err_after_9_phv", 134'(o_err), 134'(1));
      repeat (10) tick();
      check("err_sticky", 134'(o_err), 134'(1));
      do_reset("final_reset");
      check("err_cleared", 134'(o_err), 134'(0));
      check("final_drop_cnt", 134'(o_drop_cnt), 134'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
